// File: rtl/cpu_program_loader_if.sv
// cpu_program_loader_if: host byte streams, imem/dmem external ports and status of the program loader
interface cpu_program_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        busy;
  logic        err;
  modport master (
    input  in_valid, in_data, out_ready, rdata_ext, rdata_ext_2,
    output in_ready, out_valid, out_data, enable, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, err
  );
  modport slave (
    output in_valid, in_data, out_ready, rdata_ext, rdata_ext_2,
    input  in_ready, out_valid, out_data, enable, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, err
  );
endinterface

// File: rtl/cpu_program_loader.sv
// cpu_program_loader: byte-stream command parser that loads imem/dmem, reads dmem back and gates the CPU enable
module cpu_program_loader #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int READ_LAT    = 1
) (
  input logic                  clk,
  input logic                  arst_n,
  cpu_program_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, WR, RD_REQ, RD_WAIT, RD_SEND, ACK} state_t;
  state_t      state_q, state_d;
  logic        is_i_q, is_i_d, is_rd_q, is_rd_d;
  logic [15:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [23:0] hdr_q, hdr_d;
  logic [2:0]  nb_q, nb_d;
  logic [63:0] word_q, word_d;
  logic [7:0]  wait_q, wait_d;
  logic        enable_q, enable_d, err_q, err_d, busy_q, busy_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        wen_ext_q, wen_ext_d, wen_ext_2_q, wen_ext_2_d, ren_ext_2_q, ren_ext_2_d;
  logic [63:0] addr_ext_q, addr_ext_d, addr_ext_2_q, addr_ext_2_d, wdata_ext_2_q, wdata_ext_2_d;
  logic [31:0] wdata_ext_q, wdata_ext_d;
  logic        in_fire;
  logic        unused_rdata;
  assign in_fire = bus.in_valid & in_ready_q;
  assign unused_rdata = ^bus.rdata_ext;
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      is_i_q        <= 1'b0;
      is_rd_q       <= 1'b0;
      idx_q         <= '0;
      cnt_q         <= '0;
      hdr_q         <= '0;
      nb_q          <= '0;
      word_q        <= '0;
      wait_q        <= '0;
      enable_q      <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      wen_ext_q     <= 1'b0;
      wen_ext_2_q   <= 1'b0;
      ren_ext_2_q   <= 1'b0;
      addr_ext_q    <= '0;
      addr_ext_2_q  <= '0;
      wdata_ext_q   <= '0;
      wdata_ext_2_q <= '0;
    end else begin
      state_q       <= state_d;
      is_i_q        <= is_i_d;
      is_rd_q       <= is_rd_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      hdr_q         <= hdr_d;
      nb_q          <= nb_d;
      word_q        <= word_d;
      wait_q        <= wait_d;
      enable_q      <= enable_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      wen_ext_q     <= wen_ext_d;
      wen_ext_2_q   <= wen_ext_2_d;
      ren_ext_2_q   <= ren_ext_2_d;
      addr_ext_q    <= addr_ext_d;
      addr_ext_2_q  <= addr_ext_2_d;
      wdata_ext_q   <= wdata_ext_d;
      wdata_ext_2_q <= wdata_ext_2_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    is_i_d   = is_i_q;
    is_rd_d  = is_rd_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    nb_d     = nb_q;
    word_d   = word_q;
    wait_d   = wait_q;
    enable_d = enable_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (in_fire) begin
        nb_d = '0;
        case (bus.in_data)
          8'h01, 8'h02, 8'h04: begin
            state_d  = HDR;
            is_i_d   = bus.in_data == 8'h01;
            is_rd_d  = bus.in_data == 8'h04;
            enable_d = 1'b0;
          end
          8'h03:   enable_d = 1'b1;
          8'h05:   enable_d = 1'b0;
          default: err_d = 1'b1;
        endcase
      end
      HDR: if (in_fire) begin
        hdr_d = {bus.in_data, hdr_q[23:8]};
        nb_d  = nb_q + 3'd1;
        if (nb_q == 3'd3) begin
          nb_d    = '0;
          idx_d   = hdr_q[15:0];
          cnt_d   = {bus.in_data, hdr_q[23:16]};
          state_d = cnt_d == '0 ? ACK : is_rd_q ? RD_REQ : DATA;
        end
      end
      // bytes enter at the top so an imem word ends up in word_q[63:32]
      DATA: if (in_fire) begin
        word_d = {bus.in_data, word_q[63:8]};
        nb_d   = nb_q + 3'd1;
        if (nb_q == (is_i_q ? 3'd3 : 3'd7)) begin
          nb_d    = '0;
          state_d = WR;
        end
      end
      WR: begin
        idx_d   = idx_q + 16'd1;
        cnt_d   = cnt_q - 16'd1;
        state_d = cnt_q == 16'd1 ? ACK : DATA;
      end
      RD_REQ: begin
        wait_d  = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        wait_d = wait_q + 8'd1;
        if (wait_q == 8'(READ_LAT - 1)) begin
          word_d  = bus.rdata_ext_2;
          nb_d    = '0;
          state_d = RD_SEND;
        end
      end
      RD_SEND: if (bus.out_ready) begin
        word_d = {8'h00, word_q[63:8]};
        nb_d   = nb_q + 3'd1;
        if (nb_q == 3'd7) begin
          idx_d   = idx_q + 16'd1;
          cnt_d   = cnt_q - 16'd1;
          state_d = cnt_q == 16'd1 ? ACK : RD_REQ;
        end
      end
      ACK: state_d = bus.out_ready ? IDLE : ACK;
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered by decoding the upcoming state
  always_comb begin
    in_ready_d    = state_d inside {IDLE, HDR, DATA};
    out_valid_d   = state_d inside {RD_SEND, ACK};
    out_data_d    = state_d == ACK ? 8'hAC : state_d == RD_SEND ? word_d[7:0] : 8'h00;
    busy_d        = state_d != IDLE;
    wen_ext_d     = state_d == WR && is_i_d;
    wen_ext_2_d   = state_d == WR && !is_i_d;
    ren_ext_2_d   = state_d == RD_REQ;
    addr_ext_d    = 64'({idx_d[IMEM_ADDR_W-1:0], 2'b00});
    addr_ext_2_d  = 64'({idx_d[DMEM_ADDR_W-1:0], 3'b000});
    wdata_ext_d   = word_d[63:32];
    wdata_ext_2_d = word_d;
  end
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.enable      = enable_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;
  assign bus.addr_ext    = addr_ext_q;
  assign bus.wen_ext     = wen_ext_q;
  assign bus.ren_ext     = 1'b0;
  assign bus.wdata_ext   = wdata_ext_q;
  assign bus.addr_ext_2  = addr_ext_2_q;
  assign bus.wen_ext_2   = wen_ext_2_q;
  assign bus.ren_ext_2   = ren_ext_2_q;
  assign bus.wdata_ext_2 = wdata_ext_2_q;
endmodule

// File: tb/tb_cpu_program_loader.sv
// tb_cpu_program_loader: directed command sequences against a scoreboard of expected memory writes and response bytes
module tb_cpu_program_loader;
  logic clk = 1'b0;
  logic arst_n;
  logic stall;
  int   errors = 0;
  int   checks = 0;
  typedef struct {
    bit          imem;
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;
  wr_t         exp_wr[$];
  logic [7:0]  exp_out[$];
  wr_t         e;
  logic        held_v = 1'b0;
  logic [7:0]  held_d = '0;
  logic [63:0] dmem [1024];
  cpu_program_loader_if bus ();
  cpu_program_loader #(.IMEM_ADDR_W(9), .DMEM_ADDR_W(10), .READ_LAT(1)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.wen_ext_2) dmem[bus.addr_ext_2[12:3]] <= bus.wdata_ext_2;
    if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[12:3]];
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1 bus.out_ready = stall ? ~bus.out_ready : 1'b1;
  end
  initial forever begin
    @(negedge clk);
    if (bus.wen_ext || bus.wen_ext_2) begin
      if (exp_wr.size() == 0) check("write expected", 64'(exp_wr.size()), 64'd1);
      else begin
        e = exp_wr.pop_front();
        check("write port", 64'({bus.wen_ext, bus.wen_ext_2}), e.imem ? 64'd2 : 64'd1);
        check("write addr", bus.wen_ext ? bus.addr_ext : bus.addr_ext_2, e.addr);
        check("write data", bus.wen_ext ? 64'(bus.wdata_ext) : bus.wdata_ext_2, e.data);
      end
    end
    if (bus.out_valid && held_v) check("out_data stable", 64'(bus.out_data), 64'(held_d));
    held_v = bus.out_valid && !bus.out_ready;
    held_d = bus.out_data;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_out.size() == 0) check("out byte expected", 64'(exp_out.size()), 64'd1);
      else check("out byte", 64'(bus.out_data), 64'(exp_out.pop_front()));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("in_ready timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic cmd_hdr(input logic [7:0] c, input logic [15:0] idx, input logic [15:0] cnt);
    send_byte(c);
    send_byte(idx[7:0]);
    send_byte(idx[15:8]);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
  endtask
  task automatic load_word(input bit imem, input logic [15:0] idx, input logic [63:0] w);
    wr_t x;
    x.imem = imem;
    x.addr = imem ? 64'(idx[8:0]) * 64'd4 : 64'(idx[9:0]) * 64'd8;
    x.data = imem ? {32'h0, w[31:0]} : w;
    exp_wr.push_back(x);
    for (int i = 0; i < (imem ? 4 : 8); i++) send_byte(w[8*i +: 8]);
  endtask
  task automatic expect_read(input logic [63:0] w);
    for (int i = 0; i < 8; i++) exp_out.push_back(w[8*i +: 8]);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check({tag, " busy timeout"}, 64'(bus.busy), 64'd0);
    check({tag, " writes drained"}, 64'(exp_wr.size()), 64'd0);
    check({tag, " bytes drained"}, 64'(exp_out.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    stall = 1'b0;
    arst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    bus.rdata_ext = '0;
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst enable", 64'(bus.enable), 64'd0);
    check("rst err", 64'(bus.err), 64'd0);
    check("rst strobes", 64'({bus.wen_ext, bus.ren_ext, bus.wen_ext_2, bus.ren_ext_2}), 64'd0);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    exp_out.push_back(8'hAC);
    cmd_hdr(8'h01, 16'h0000, 16'h0002);
    load_word(1'b1, 16'h0000, 64'h0000_0013);
    load_word(1'b1, 16'h0001, 64'h0010_8093);
    wait_idle("load_i");
    exp_out.push_back(8'hAC);
    cmd_hdr(8'h02, 16'h03FF, 16'h0002);
    load_word(1'b0, 16'h03FF, 64'h0706050403020100);
    load_word(1'b0, 16'h0400, 64'h0F0E0D0C0B0A0908);
    wait_idle("load_d wrap");
    exp_out.push_back(8'hAC);
    cmd_hdr(8'h02, 16'h0005, 16'h0001);
    load_word(1'b0, 16'h0005, 64'h1122334455667788);
    wait_idle("load_d idx5");
    expect_read(64'h1122334455667788);
    exp_out.push_back(8'hAC);
    stall = 1'b1;
    cmd_hdr(8'h04, 16'h0005, 16'h0001);
    wait_idle("read_d stalled");
    stall = 1'b0;
    expect_read(64'h0706050403020100);
    expect_read(64'h0F0E0D0C0B0A0908);
    exp_out.push_back(8'hAC);
    cmd_hdr(8'h04, 16'h03FF, 16'h0002);
    wait_idle("read_d wrap");
    send_byte(8'h03);
    check("run enable", 64'(bus.enable), 64'd1);
    check("run busy", 64'(bus.busy), 64'd0);
    send_byte(8'h05);
    check("halt enable", 64'(bus.enable), 64'd0);
    send_byte(8'h03);
    check("run again enable", 64'(bus.enable), 64'd1);
    exp_out.push_back(8'hAC);
    send_byte(8'h02);
    check("load cmd clears enable", 64'(bus.enable), 64'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_idle("load_d cnt0");
    send_byte(8'h07);
    check("unknown err", 64'(bus.err), 64'd1);
    check("unknown busy", 64'(bus.busy), 64'd0);
    check("unknown in_ready", 64'(bus.in_ready), 64'd1);
    send_byte(8'h03);
    cmd_hdr(8'h02, 16'h0009, 16'h0001);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    arst_n = 1'b0;
    @(posedge clk);
    #1 arst_n = 1'b1;
    check("mid rst busy", 64'(bus.busy), 64'd0);
    check("mid rst enable", 64'(bus.enable), 64'd0);
    check("mid rst err", 64'(bus.err), 64'd0);
    check("mid rst in_ready", 64'(bus.in_ready), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    exp_out.push_back(8'hAC);
    cmd_hdr(8'h02, 16'h0009, 16'h0001);
    load_word(1'b0, 16'h0009, 64'hCAFEF00D_DEADBEEF);
    wait_idle("load_d after rst");
    expect_read(64'hCAFEF00D_DEADBEEF);
    exp_out.push_back(8'hAC);
    cmd_hdr(8'h04, 16'h0009, 16'h0001);
    wait_idle("read_d after rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
